// File: rtl/addr_map_pkg.sv
// MIPS-style virtual memory map and the kseg0/kseg1 unmapped translation.
package addr_map_pkg;

    localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
    localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
    localparam logic [31:0] KSEG2_BASE = 32'hC000_0000;

    typedef struct packed {
        logic [31:0] phys;
        logic        uncached;
    } xlat_t;

    // kseg0/kseg1 alias the low 512 MB; everything else is passed through untouched.
    function automatic xlat_t virt_to_phys(input logic [31:0] addr);
        xlat_t r;
        r.phys     = addr;
        r.uncached = 1'b0;
        if (addr >= KSEG0_BASE && addr < KSEG2_BASE) begin
            r.phys     = {3'b000, addr[28:0]};
            r.uncached = (addr >= KSEG1_BASE);
        end
        return r;
    endfunction

endpackage

// File: rtl/cbus_pkg.sv
// Common CBus header: request/response beat formats shared by every master and slave.
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [3:0]  len;       // beats minus one
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational request picker: lowest index (mode=0) or first index at/after ptr with wrap (mode=1).
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] start;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        pos   = '0;
        start = mode ? ptr : '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, start} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            pos = sum[IDX_W-1:0];
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/cbus_xlat_arbiter.sv
// N-master CBus arbiter with burst-long grant hold and kseg0/kseg1 translation on the granted request.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | no burst in flight; outputs zero; arbitrate any valid master
//  BUSY  | grant_idx owns the bus until a response beat with last=1
module cbus_xlat_arbiter
    import cbus_pkg::*;
    import addr_map_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int ARB_MODE   = 0,
    parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             uncached,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] grant_n;
    logic [IDX_W-1:0] rr_ptr, rr_n;
    logic [NUM_INPUTS-1:0] req_vec;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             burst_done;
    cbus_req_t        sel_req;
    xlat_t            xl;

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            req_vec[i] = ireqs[i].valid;
        end
    end

    rr_picker #(
        .N     (NUM_INPUTS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req_vec),
        .ptr   (rr_ptr),
        .mode  (ARB_MODE == 1),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign burst_done = oresp.ready && oresp.last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_n;
            grant_idx <= grant_n;
            rr_ptr    <= rr_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant_idx;
        rr_n    = rr_ptr;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = BUSY;
                    grant_n = pick_idx;
                end
            end
            BUSY: begin
                if (burst_done) begin
                    state_n = IDLE;
                    // Pointer moves past the finisher so it is searched last next time.
                    if (ARB_MODE == 1) begin
                        rr_n = (grant_idx == IDX_W'(NUM_INPUTS-1)) ? '0 : grant_idx + IDX_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign sel_req = ireqs[grant_idx];
    assign xl      = virt_to_phys(sel_req.addr);
    assign busy    = (state == BUSY);

    always_comb begin
        oreq     = '0;
        uncached = 1'b0;
        if (busy) begin
            oreq      = sel_req;
            oreq.addr = xl.phys;
            uncached  = xl.uncached;
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = (busy && grant_idx == IDX_W'(i)) ? oresp : '0;
        end
    end

    a_granted_holds_valid: assert property (
        @(posedge clk) disable iff (reset)
        busy |-> sel_req.valid
    );

    a_granted_req_stable: assert property (
        @(posedge clk) disable iff (reset)
        (busy && !burst_done) |=> $stable(sel_req)
    );

endmodule
